// File: rtl/rll_key_pkg.sv
// Shared types and constants for the RLL serial key loader.
// Optional feature macro: RLL_KEY_PARITY_CHECK_EN.
package rll_key_pkg;

  localparam int RLL_KEY_WIDTH_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    PARITY,
    COMMIT,
    DONE,
    ERROR
  } rll_key_state_t;

  function automatic int rll_key_cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/rll_key_loader.sv
// Serial key loader: shifts the unlock key into a shadow register and commits it whole.
// Optional macro RLL_KEY_PARITY_CHECK_EN adds an even-parity beat and an error state.
module rll_key_loader
  import rll_key_pkg::*;
#(
  parameter int KEY_WIDTH = RLL_KEY_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 key_load_start,
  input  logic                 key_sdi,
  input  logic                 key_sdi_valid,
  output logic                 key_sdi_ready,
  output logic [KEY_WIDTH-1:0] key_out,
  output logic                 key_valid,
  output logic                 key_busy,
  output logic                 key_err
);

  localparam int CW = rll_key_cnt_w(KEY_WIDTH);

  rll_key_state_t state, state_nxt;

  logic [KEY_WIDTH-1:0] shadow, shadow_nxt;
  logic [KEY_WIDTH-1:0] key_nxt;
  logic [CW-1:0]        bit_cnt, cnt_nxt;
  logic                 valid_nxt;
  logic                 beat;
  logic                 last;

`ifdef RLL_KEY_PARITY_CHECK_EN
  logic err_q, err_nxt;
  assign key_err = err_q;
`else
  assign key_err = 1'b0;
`endif

  assign key_busy      = (state == SHIFT) || (state == PARITY);
  assign key_sdi_ready = key_busy && !key_load_start;
  assign beat          = key_sdi_valid && key_sdi_ready;
  assign last          = (bit_cnt == CW'(KEY_WIDTH - 1));

  // Next-state, shadow fill and commit decisions.
  always_comb begin
    state_nxt  = state;
    shadow_nxt = shadow;
    cnt_nxt    = bit_cnt;
    key_nxt    = key_out;
    valid_nxt  = key_valid;
`ifdef RLL_KEY_PARITY_CHECK_EN
    err_nxt    = err_q;
`endif
    if (key_load_start) begin
      state_nxt  = SHIFT;
      shadow_nxt = '0;
      cnt_nxt    = '0;
      key_nxt    = '0;
      valid_nxt  = 1'b0;
`ifdef RLL_KEY_PARITY_CHECK_EN
      err_nxt    = 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: ;
        SHIFT: begin
          if (beat) begin
            for (int i = 0; i < KEY_WIDTH; i++) begin
              if (bit_cnt == CW'(i)) shadow_nxt[i] = key_sdi;
            end
            cnt_nxt = bit_cnt + CW'(1);
            if (last) begin
`ifdef RLL_KEY_PARITY_CHECK_EN
              state_nxt = PARITY;
`else
              state_nxt = COMMIT;
`endif
            end
          end
        end
`ifdef RLL_KEY_PARITY_CHECK_EN
        PARITY: begin
          if (beat) begin
            if ((^shadow) ^ key_sdi) begin
              state_nxt = ERROR;
              err_nxt   = 1'b1;
              key_nxt   = '0;
              valid_nxt = 1'b0;
            end else begin
              state_nxt = COMMIT;
            end
          end
        end
        ERROR: ;
`endif
        COMMIT: begin
          key_nxt   = shadow;
          valid_nxt = 1'b1;
          state_nxt = DONE;
        end
        DONE: ;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State, shadow and committed-key registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shadow    <= '0;
      bit_cnt   <= '0;
      key_out   <= '0;
      key_valid <= 1'b0;
`ifdef RLL_KEY_PARITY_CHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      shadow    <= shadow_nxt;
      bit_cnt   <= cnt_nxt;
      key_out   <= key_nxt;
      key_valid <= valid_nxt;
`ifdef RLL_KEY_PARITY_CHECK_EN
      err_q     <= err_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_rll_key_loader.sv
// Directed and randomized bench for rll_key_loader.
// Parity tests run only when RLL_KEY_PARITY_CHECK_EN is defined.
module tb_rll_key_loader;
  import rll_key_pkg::*;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_load_start;
  logic         key_sdi;
  logic         key_sdi_valid;
  logic         key_sdi_ready;
  logic [W-1:0] key_out;
  logic         key_valid;
  logic         key_busy;
  logic         key_err;

  int checks = 0;
  int errors = 0;

  rll_key_loader #(.KEY_WIDTH(W)) dut (
    .clk            (clk),
    .rst            (rst),
    .key_load_start (key_load_start),
    .key_sdi        (key_sdi),
    .key_sdi_valid  (key_sdi_valid),
    .key_sdi_ready  (key_sdi_ready),
    .key_out        (key_out),
    .key_valid      (key_valid),
    .key_busy       (key_busy),
    .key_err        (key_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: a load fails only when parity is compiled in and odd overall.
  function automatic bit load_bad(input logic [W-1:0] k, input bit p);
`ifdef RLL_KEY_PARITY_CHECK_EN
    return ((($countones(k) + int'(p)) % 2) != 0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input bit gaps);
    int n;
    n = 0;
    if (gaps) begin
      while ($urandom_range(1, 0) == 1 && n < 8) begin
        key_sdi_valid = 1'b0;
        key_sdi = 1'($urandom);
        tick();
        n++;
      end
    end
    key_sdi = b;
    key_sdi_valid = 1'b1;
    #1;
    chk("ready_on_beat", key_sdi_ready, 1);
    tick();
    key_sdi_valid = 1'b0;
  endtask

  task automatic start_load();
    key_load_start = 1'b1;
    tick();
    key_load_start = 1'b0;
    chk("start_busy", key_busy, 1);
    chk("start_key_clr", key_out, 0);
    chk("start_valid_clr", key_valid, 0);
    chk("start_err_clr", key_err, 0);
  endtask

  task automatic shift_and_check(input logic [W-1:0] k, input bit p,
                                 input bit gaps);
    bit bad;
    for (int i = 0; i < W; i++) send_bit(k[i], gaps);
`ifdef RLL_KEY_PARITY_CHECK_EN
    send_bit(p, gaps);
`endif
    bad = load_bad(k, p);
    chk("commit_busy", key_busy, 0);
    chk("commit_ready", key_sdi_ready, 0);
    chk("commit_valid_lo", key_valid, 0);
    tick();
    chk("done_valid", key_valid, !bad);
    chk("done_key", key_out, bad ? '0 : k);
    chk("done_err", key_err, bad);
    chk("done_busy", key_busy, 0);
  endtask

  initial begin
    logic [W-1:0] k;
    bit p;

    rst = 1'b1;
    key_load_start = 1'b0;
    key_sdi = 1'b0;
    key_sdi_valid = 1'b0;
    @(negedge clk);
    tick();
    chk("rst_key", key_out, 0);
    chk("rst_valid", key_valid, 0);
    chk("rst_busy", key_busy, 0);
    chk("rst_err", key_err, 0);
    chk("rst_ready", key_sdi_ready, 0);
    rst = 1'b0;
    tick();

    key_sdi_valid = 1'b1;
    #1;
    chk("idle_ready", key_sdi_ready, 0);
    tick();
    key_sdi_valid = 1'b0;

    // Gap-free A5C3, correct parity.
    start_load();
    shift_and_check(16'hA5C3, 1'b0, 1'b0);

`ifdef RLL_KEY_PARITY_CHECK_EN
    // Wrong parity must land in the error state.
    start_load();
    shift_and_check(16'hA5C3, 1'b1, 1'b0);
    key_sdi_valid = 1'b1;
    tick();
    key_sdi_valid = 1'b0;
    chk("err_held", key_err, 1);
    chk("err_key_zero", key_out, 0);
    start_load();
    shift_and_check(16'hA5C3, 1'b0, 1'b0);
`endif

    // Abort a partial FFFF load, then load 0001.
    start_load();
    for (int i = 0; i < 7; i++) send_bit(1'b1, 1'b0);
    chk("partial_key_hidden", key_out, 0);
    start_load();
    shift_and_check(16'h0001, 1'b0, 1'b0);

    // Start and a valid beat in the same cycle: beat dropped.
    start_load();
    send_bit(1'b1, 1'b0);
    key_load_start = 1'b1;
    key_sdi = 1'b1;
    key_sdi_valid = 1'b1;
    #1;
    chk("start_blocks_ready", key_sdi_ready, 0);
    tick();
    key_load_start = 1'b0;
    key_sdi_valid = 1'b0;
    chk("restart_cnt", dut.bit_cnt, 0);
    chk("restart_busy", key_busy, 1);
    shift_and_check(16'h1234, 1'b0, 1'b0);

    // Random gaps give the same result; beats in DONE are ignored.
    start_load();
    shift_and_check(16'h3C5A, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      key_sdi = 1'($urandom);
      key_sdi_valid = 1'b1;
      #1;
      chk("done_ready", key_sdi_ready, 0);
      tick();
      chk("done_key_hold", key_out, 16'h3C5A);
      chk("done_valid_hold", key_valid, 1);
    end
    key_sdi_valid = 1'b0;

    // Random keys, random gaps, random parity bit.
    for (int n = 0; n < 6; n++) begin
      k = W'($urandom);
      p = 1'($urandom);
      start_load();
      shift_and_check(k, p, 1'b1);
    end

    // Ensure a committed nonzero key before the reset test.
    start_load();
    shift_and_check(16'h3C5A, 1'b0, 1'b0);

    // Reset in the middle of a load.
    start_load();
    for (int i = 0; i < 9; i++) send_bit(1'b1, 1'b0);
    rst = 1'b1;
    key_sdi_valid = 1'b1;
    tick();
    chk("midrst_key", key_out, 0);
    chk("midrst_valid", key_valid, 0);
    chk("midrst_busy", key_busy, 0);
    chk("midrst_err", key_err, 0);
    chk("midrst_ready", key_sdi_ready, 0);
    chk("midrst_state", dut.state, IDLE);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("postrst_ready", key_sdi_ready, 0);
      chk("postrst_busy", key_busy, 0);
    end
    key_sdi_valid = 1'b0;
    start_load();
    shift_and_check(16'hBEEF, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
